// File: rtl/ps2_move_queue_pkg.sv
// Shared constants for the PS/2 direction queue and the snake game core:
// direction encodings, set-2 scancodes and decoder state encodings.
package ps2_move_queue_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // WASD (plain make codes)
  localparam logic [7:0] SC_W = 8'h1D;
  localparam logic [7:0] SC_D = 8'h23;
  localparam logic [7:0] SC_S = 8'h1B;
  localparam logic [7:0] SC_A = 8'h1C;

  // Arrow keys (E0-prefixed make codes)
  localparam logic [7:0] SC_ARR_UP    = 8'h75;
  localparam logic [7:0] SC_ARR_RIGHT = 8'h74;
  localparam logic [7:0] SC_ARR_DOWN  = 8'h72;
  localparam logic [7:0] SC_ARR_LEFT  = 8'h6B;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } dec_state_t;

  // Opposite direction: flipping bit 1 turns up<->down and right<->left.
  function automatic logic [1:0] dir_reverse(input logic [1:0] d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/ps2_move_queue_fifo2.sv
// Two-entry, 2-bit direction FIFO. Entry 0 is always the head; a pop shifts
// entry 1 down, so a simultaneous push and pop on a full FIFO stays full.
module dir_fifo2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic [1:0] i_din,
  output logic [1:0] o_head,
  output logic [1:0] o_tail,
  output logic [1:0] o_count
);

  logic [1:0] r_mem [2];
  logic [1:0] r_count;
  logic       w_pop;
  logic       w_push;

  // Pop is only meaningful with data present; push needs room unless a pop frees it.
  always_comb begin
    w_pop  = i_pop && (r_count != 2'd0);
    w_push = i_push && ((r_count != 2'd2) || w_pop);
  end

  // Occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= 2'd0;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + 2'd1;
    end else if (w_pop && !w_push) begin
      r_count <= r_count - 2'd1;
    end
  end

  // Storage: shift on pop, write at the slot following the post-pop occupancy.
  always_ff @(posedge clk) begin
    if (w_pop) begin
      r_mem[0] <= r_mem[1];
      if (w_push) begin
        if (r_count == 2'd1) r_mem[0] <= i_din;
        else                 r_mem[1] <= i_din;
      end
    end else if (w_push) begin
      r_mem[r_count[0]] <= i_din;
    end
  end

  assign o_head  = r_mem[0];
  assign o_tail  = (r_count == 2'd2) ? r_mem[1] : r_mem[0];
  assign o_count = r_count;

endmodule

// File: rtl/ps2_move_queue.sv
// PS/2 set-2 scancode to snake direction converter with a 2-deep turn queue.
// Reversals and repeats of the latest queued/committed direction are dropped.
module ps2_move_queue
  import ps2_move_queue_pkg::*;
#(
  parameter logic [1:0] START_DIR = 2'b01
) (
  input  logic       mclk,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_data,
  input  logic       game_tick,
  output logic [1:0] move,
  output logic [1:0] q_count,
  output logic       key_drop
);

  dec_state_t r_state;
  logic [1:0] r_move;
  logic       r_key_drop;

  logic       w_make_vld;
  logic       w_ext;
  logic       w_key_vld;
  logic [1:0] w_key_dir;
  logic [1:0] w_ref_dir;
  logic       w_reject;
  logic       w_push;
  logic       w_pop;
  logic [1:0] w_head;
  logic [1:0] w_tail;
  logic [1:0] w_count;

  // Prefix decoder: tracks E0 / F0 across received bytes.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else if (rx_done) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == SC_EXT)      r_state <= ST_EXT;
          else if (rx_data == SC_BRK) r_state <= ST_BRK;
          else                        r_state <= ST_IDLE;
        end
        ST_EXT: begin
          if (rx_data == SC_BRK) r_state <= ST_EXT_BRK;
          else                   r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Make-code detection and key-to-direction mapping for this cycle's byte.
  always_comb begin
    w_ext      = (r_state == ST_EXT);
    w_make_vld = rx_done &&
                 (((r_state == ST_IDLE) && (rx_data != SC_EXT) && (rx_data != SC_BRK)) ||
                  (w_ext && (rx_data != SC_BRK)));
    w_key_vld  = 1'b0;
    w_key_dir  = DIR_UP;
    if (w_make_vld) begin
      if (w_ext) begin
        case (rx_data)
          SC_ARR_UP:    begin w_key_vld = 1'b1; w_key_dir = DIR_UP;    end
          SC_ARR_RIGHT: begin w_key_vld = 1'b1; w_key_dir = DIR_RIGHT; end
          SC_ARR_DOWN:  begin w_key_vld = 1'b1; w_key_dir = DIR_DOWN;  end
          SC_ARR_LEFT:  begin w_key_vld = 1'b1; w_key_dir = DIR_LEFT;  end
          default:      w_key_vld = 1'b0;
        endcase
      end else begin
        case (rx_data)
          SC_W:    begin w_key_vld = 1'b1; w_key_dir = DIR_UP;    end
          SC_D:    begin w_key_vld = 1'b1; w_key_dir = DIR_RIGHT; end
          SC_S:    begin w_key_vld = 1'b1; w_key_dir = DIR_DOWN;  end
          SC_A:    begin w_key_vld = 1'b1; w_key_dir = DIR_LEFT;  end
          default: w_key_vld = 1'b0;
        endcase
      end
    end
  end

  // Accept rule against the pre-pop reference direction.
  always_comb begin
    w_ref_dir = (w_count != 2'd0) ? w_tail : r_move;
    w_reject  = (w_key_dir == w_ref_dir) ||
                (w_key_dir == dir_reverse(w_ref_dir)) ||
                ((w_count == 2'd2) && !game_tick);
    w_push    = w_key_vld && !w_reject;
    w_pop     = game_tick && (w_count != 2'd0);
  end

  dir_fifo2 u_fifo (
    .clk     (mclk),
    .rst     (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_key_dir),
    .o_head  (w_head),
    .o_tail  (w_tail),
    .o_count (w_count)
  );

  // Commit the queue head on a tick; flag rejected direction keys for one cycle.
  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      r_move     <= START_DIR;
      r_key_drop <= 1'b0;
    end else begin
      if (w_pop) r_move <= w_head;
      r_key_drop <= w_key_vld && w_reject;
    end
  end

  assign move     = r_move;
  assign q_count  = w_count;
  assign key_drop = r_key_drop;

endmodule
